// File: rtl/frac_div_monitor.sv
// Half-integer divided-clock monitor: measures div_in period/high time in half-clk units.
// Optional error/timeout counter port err_cnt enabled by FRAC_DIV_MON_ERRCNT_EN.
module frac_div_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXP_PERIOD = 9,
    parameter int unsigned EXP_HIGH   = 4,
    parameter int unsigned LOCK_CNT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_vld,
    output logic             err,
    output logic             lock,
    output logic             timeout
`ifdef FRAC_DIV_MON_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
    localparam logic [SUM_W-1:0] HC_MAX = SUM_W'((2 ** CNT_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        LOCKED
    } state_t;

    state_t state, state_nxt;

    logic p_smp, n_smp;
    logic [CNT_W-1:0] hc_cnt, hc_nxt;
    logic [CNT_W-1:0] high_lat, high_lat_nxt;
    logic fall_seen, fall_seen_nxt;
    logic [LOCK_W-1:0] match_cnt, match_nxt;
    logic [CNT_W-1:0] period_nxt, high_nxt;
    logic vld_nxt, err_nxt, lock_nxt, tmo_nxt;

    logic rise1, fall1, rise2, fall2;
    logic [SUM_W-1:0] hc_p1, hc_p2;
    logic close_evt, is_match;
    logic [CNT_W-1:0] close_per, close_high;

    // First half: previous posedge sample -> negedge sample; second half: negedge -> now.
    assign rise1 = ~p_smp & n_smp;
    assign fall1 = p_smp & ~n_smp;
    assign rise2 = ~n_smp & div_in;
    assign fall2 = n_smp & ~div_in;
    assign hc_p1 = {1'b0, hc_cnt} + SUM_W'(1);
    assign hc_p2 = {1'b0, hc_cnt} + SUM_W'(2);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) n_smp <= 1'b0;
        else     n_smp <= div_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Both half-cycle transitions are applied in time order within one evaluation.
    always_comb begin
        state_nxt     = state;
        hc_nxt        = (hc_p2 >= HC_MAX) ? CNT_W'(HC_MAX) : CNT_W'(hc_p2);
        high_lat_nxt  = high_lat;
        fall_seen_nxt = fall_seen;
        match_nxt     = match_cnt;
        period_nxt    = period_o;
        high_nxt      = high_o;
        vld_nxt       = 1'b0;
        err_nxt       = 1'b0;
        tmo_nxt       = 1'b0;
        lock_nxt      = lock;
        close_evt     = 1'b0;
        close_per     = '0;
        close_high    = '0;
        is_match      = 1'b0;

        if (rise1) begin
            if (state != IDLE) begin
                close_evt  = 1'b1;
                close_per  = CNT_W'(hc_p1);
                close_high = fall_seen ? high_lat : CNT_W'(hc_p1);
            end
            hc_nxt        = CNT_W'(1);
            fall_seen_nxt = 1'b0;
        end else if (fall1 && state != IDLE) begin
            high_lat_nxt  = CNT_W'(hc_p1);
            fall_seen_nxt = 1'b1;
        end

        if (rise2) begin
            if (state != IDLE) begin
                close_evt  = 1'b1;
                close_per  = CNT_W'(hc_p2);
                close_high = fall_seen_nxt ? high_lat_nxt : CNT_W'(hc_p2);
            end
            hc_nxt        = '0;
            fall_seen_nxt = 1'b0;
        end else if (fall2) begin
            if (rise1) begin
                high_lat_nxt  = CNT_W'(1);
                fall_seen_nxt = 1'b1;
            end else if (state != IDLE) begin
                high_lat_nxt  = CNT_W'(hc_p2);
                fall_seen_nxt = 1'b1;
            end
        end

        is_match = (close_per == CNT_W'(EXP_PERIOD)) && (close_high == CNT_W'(EXP_HIGH));

        case (state)
            IDLE: begin
                if (rise1 || rise2) state_nxt = MEAS;
            end
            MEAS, LOCKED: begin
                if (close_evt) begin
                    vld_nxt    = 1'b1;
                    period_nxt = close_per;
                    high_nxt   = close_high;
                    if (is_match) begin
                        match_nxt = (match_cnt >= LOCK_W'(LOCK_CNT)) ? match_cnt
                                                                      : match_cnt + LOCK_W'(1);
                        if (match_nxt >= LOCK_W'(LOCK_CNT)) begin
                            state_nxt = LOCKED;
                            lock_nxt  = 1'b1;
                        end
                    end else begin
                        err_nxt   = 1'b1;
                        match_nxt = '0;
                        lock_nxt  = 1'b0;
                        state_nxt = MEAS;
                    end
                end else if (hc_p2 >= HC_MAX) begin
                    tmo_nxt   = 1'b1;
                    lock_nxt  = 1'b0;
                    match_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_smp     <= 1'b0;
            hc_cnt    <= '0;
            high_lat  <= '0;
            fall_seen <= 1'b0;
            match_cnt <= '0;
            period_o  <= '0;
            high_o    <= '0;
            meas_vld  <= 1'b0;
            err       <= 1'b0;
            lock      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            p_smp     <= div_in;
            hc_cnt    <= hc_nxt;
            high_lat  <= high_lat_nxt;
            fall_seen <= fall_seen_nxt;
            match_cnt <= match_nxt;
            period_o  <= period_nxt;
            high_o    <= high_nxt;
            meas_vld  <= vld_nxt;
            err       <= err_nxt;
            lock      <= lock_nxt;
            timeout   <= tmo_nxt;
        end
    end

`ifdef FRAC_DIV_MON_ERRCNT_EN
    // Saturating tally of mismatch and timeout pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        err_cnt <= 8'd0;
        else if ((err_nxt || tmo_nxt) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_frac_div_monitor.sv
// Bench for frac_div_monitor: half-cycle sample stream checked against an event-time model.
module tb_frac_div_monitor;

    logic       clk;
    logic       rst;
    logic       div_in;
    logic [7:0] period_o;
    logic [7:0] high_o;
    logic       meas_vld;
    logic       err;
    logic       lock;
    logic       timeout;
`ifdef FRAC_DIV_MON_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    frac_div_monitor dut (
        .clk      (clk),
        .rst      (rst),
        .div_in   (div_in),
        .period_o (period_o),
        .high_o   (high_o),
        .meas_vld (meas_vld),
        .err      (err),
        .lock     (lock),
        .timeout  (timeout)
`ifdef FRAC_DIV_MON_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: absolute half-cycle timestamps of rises and falls.
    int  ht, last_rise, last_fall, m_match, m_ecnt;
    bit  m_prev, m_active, m_lock, fall_seen, rose;
    int  e_period, e_high;
    bit  e_vld, e_err, e_tmo;
    int  sq[$];
    int  tmo_seen, vld_total, vld_at_lock;
    bit  lock_q;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        ht = 0; last_rise = 0; last_fall = 0; m_match = 0; m_ecnt = 0;
        m_prev = 0; m_active = 0; m_lock = 0; fall_seen = 0;
        e_period = 0; e_high = 0; e_vld = 0; e_err = 0; e_tmo = 0;
        vld_total = 0; vld_at_lock = -1; lock_q = 0;
    endtask

    task automatic model_sample(input bit v);
        int per, hi;
        ht++;
        if (v && !m_prev) begin
            if (m_active) begin
                per = ht - last_rise;
                hi  = fall_seen ? (last_fall - last_rise) : per;
                e_vld = 1; e_period = per; e_high = hi;
                if (per == 9 && hi == 4) begin
                    m_match = (m_match >= 4) ? 4 : m_match + 1;
                    if (m_match >= 4) m_lock = 1;
                end else begin
                    e_err = 1; m_match = 0; m_lock = 0;
                    if (m_ecnt < 255) m_ecnt++;
                end
            end else begin
                m_active = 1;
            end
            last_rise = ht; fall_seen = 0; rose = 1;
        end else if (!v && m_prev && m_active) begin
            last_fall = ht; fall_seen = 1;
        end
        m_prev = v;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_period"}, int'(period_o), e_period);
        chk({tag, "_high"}, int'(high_o), e_high);
        chk({tag, "_vld"}, int'(meas_vld), int'(e_vld));
        chk({tag, "_err"}, int'(err), int'(e_err));
        chk({tag, "_lock"}, int'(lock), int'(m_lock));
        chk({tag, "_tmo"}, int'(timeout), int'(e_tmo));
`ifdef FRAC_DIV_MON_ERRCNT_EN
        chk({tag, "_errcnt"}, int'(err_cnt), m_ecnt);
`endif
    endtask

    // One clk cycle: a is sampled at negedge, b at the following posedge.
    task automatic cycle(input bit a, input bit b, input string tag);
        div_in = a;
        @(negedge clk);
        #1 div_in = b;
        @(posedge clk);
        #2;
        e_vld = 0; e_err = 0; e_tmo = 0; rose = 0;
        model_sample(a);
        model_sample(b);
        if (m_active && !rose && (ht - last_rise) >= 255) begin
            e_tmo = 1; m_lock = 0; m_match = 0; m_active = 0;
            if (m_ecnt < 255) m_ecnt++;
        end
        if (timeout) tmo_seen++;
        if (meas_vld) vld_total++;
        if (lock && !lock_q && vld_at_lock < 0) vld_at_lock = vld_total;
        lock_q = lock;
        check_outputs(tag);
    endtask

    task automatic push_period(input int hi, input int per);
        for (int i = 0; i < hi; i++) sq.push_back(1);
        for (int i = hi; i < per; i++) sq.push_back(0);
    endtask

    task automatic pump(input string tag);
        int a, b;
        while (sq.size() >= 2) begin
            a = sq.pop_front();
            b = sq.pop_front();
            cycle(a[0], b[0], tag);
        end
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        sq.delete();
        check_outputs(tag);
        @(posedge clk);
        #2;
        check_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        int per, hi;
        rst = 1'b1;
        div_in = 1'b0;
        tmo_seen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_outputs("reset");
        rst = 1'b0;

        // Ideal divide-by-4.5: lock after the 4th matching period.
        for (int i = 0; i < 10; i++) push_period(4, 9);
        pump("ideal");
        chk("ideal_period_const", int'(period_o), 9);
        chk("ideal_high_const", int'(high_o), 4);
        chk("ideal_lock_const", int'(lock), 1);
        chk("ideal_vld_at_lock", vld_at_lock, 4);

        // One long period breaks lock, then relock.
        push_period(4, 10);
        for (int i = 0; i < 6; i++) push_period(4, 9);
        pump("long");
        chk("long_relock", int'(lock), 1);

        // Stuck low: single timeout, then resume.
        sq.push_back(1);
        for (int i = 0; i < 300; i++) sq.push_back(0);
        pump("stuck");
        chk("stuck_tmo_count", tmo_seen, 1);
        chk("stuck_lock_low", int'(lock), 0);
        for (int i = 0; i < 6; i++) push_period(4, 9);
        pump("resume");

        // One-half-cycle high pulse, period 9.
        for (int i = 0; i < 3; i++) push_period(1, 9);
        sq.push_back(1);
        if (sq.size() % 2 != 0) sq.push_back(0);
        pump("narrow");
        chk("narrow_high_const", int'(high_o), 1);
        chk("narrow_period_const", int'(period_o), 9);

        // Reset in the middle of a period.
        push_period(4, 9);
        push_period(4, 9);
        sq.push_back(1);
        sq.push_back(1);
        sq.push_back(1);
        if (sq.size() % 2 != 0) sq.push_back(1);
        pump("pre_rst");
        apply_reset("mid_rst");
        for (int i = 0; i < 6; i++) push_period(4, 9);
        pump("post_rst");

        // Random periods, half of them ideal, one long gap.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1, 0) == 0) begin
                push_period(4, 9);
            end else begin
                per = int'($urandom_range(20, 2));
                hi  = int'($urandom_range(per - 1, 1));
                push_period(hi, per);
            end
            if (i == 30) begin
                sq.push_back(1);
                for (int k = 0; k < 270; k++) sq.push_back(0);
            end
        end
        pump("rand");

`ifdef FRAC_DIV_MON_ERRCNT_EN
        // Error counter saturates.
        for (int i = 0; i < 300; i++) push_period(4, 10);
        pump("errcnt");
        chk("errcnt_sat", int'(err_cnt), 255);
`endif

        sq.push_back(0);
        if (sq.size() % 2 != 0) sq.push_back(0);
        pump("tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
